// File: rtl/tbcm_weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: zero-latency grant from IDLE, grant held until freed.
// Optional forced release after TIMEOUT granted cycles when TBCM_WRR_TIMEOUT_EN is defined.
module tbcm_weighted_round_robin_arbiter #(
  parameter int REQUESTS     = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTS-1:0]              i_request,
  input  logic [REQUESTS*WEIGHT_WIDTH-1:0] i_weight,
  input  logic [REQUESTS-1:0]              i_free,
  output logic [REQUESTS-1:0]              o_grant,
  output logic                             o_busy,
  output logic                             o_timeout
);
  localparam int IW = $clog2(REQUESTS);

  typedef enum logic [0:0] {IDLE, GRANTED} state_t;

  if (REQUESTS < 2 || TIMEOUT < 2) begin : g_param_check
    $error("tbcm_weighted_round_robin_arbiter: REQUESTS and TIMEOUT must be >= 2");
  end

  state_t                  state_reg, state_next;
  logic [IW-1:0]           winner_reg;
  logic [IW-1:0]           ptr_reg;
  logic [WEIGHT_WIDTH-1:0] credit_reg [REQUESTS];
  logic [WEIGHT_WIDTH-1:0] w_eff [REQUESTS];
  logic [REQUESTS-1:0]     eligible;
  logic [REQUESTS-1:0]     cand;
  logic                    reload;
  logic                    found;
  logic [IW-1:0]           win_idx;
  logic [WEIGHT_WIDTH-1:0] win_left;
  logic                    arb_en;
  logic                    grant_fire;
  logic                    release_now;
  logic [REQUESTS-1:0]     grant;

  // A weight of zero behaves as one grant per round.
  for (genvar gi = 0; gi < REQUESTS; gi++) begin : g_req
    assign w_eff[gi] = (i_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0) ?
                       WEIGHT_WIDTH'(1) : i_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign eligible[gi] = i_request[gi] && (credit_reg[gi] != '0);
  end

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQUESTS) s = s - REQUESTS;
    return IW'(s);
  endfunction

`ifdef TBCM_WRR_TIMEOUT_EN
  localparam int HW = $clog2(TIMEOUT + 1);
  logic [HW-1:0] hold_cnt_reg;
  logic          timeout_reg;
  logic          timeout_next;
  assign arb_en    = (state_reg == IDLE) && !timeout_reg;
  assign o_timeout = timeout_reg;
`else
  assign arb_en    = (state_reg == IDLE);
  assign o_timeout = 1'b0;
`endif

  // Circular search from the pointer; with no credited requester, everyone reloads.
  always_comb begin
    reload  = (eligible == '0);
    cand    = reload ? i_request : eligible;
    found   = 1'b0;
    win_idx = ptr_reg;
    for (int k = 0; k < REQUESTS; k++) begin
      if (!found && cand[wrap_add(ptr_reg, k)]) begin
        found   = 1'b1;
        win_idx = wrap_add(ptr_reg, k);
      end
    end
    win_left = reload ? (w_eff[win_idx] - WEIGHT_WIDTH'(1))
                      : (credit_reg[win_idx] - WEIGHT_WIDTH'(1));
  end

  assign grant_fire = arb_en && (i_request != '0);

  always_comb begin
    state_next  = state_reg;
    release_now = 1'b0;
`ifdef TBCM_WRR_TIMEOUT_EN
    timeout_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_fire) state_next = GRANTED;
      end
      GRANTED: begin
        if (i_free[winner_reg]) begin
          state_next  = IDLE;
          release_now = 1'b1;
        end
`ifdef TBCM_WRR_TIMEOUT_EN
        else if (hold_cnt_reg == HW'(TIMEOUT - 1)) begin
          state_next   = IDLE;
          release_now  = 1'b1;
          timeout_next = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_reg <= '0;
      ptr_reg    <= '0;
      for (int i = 0; i < REQUESTS; i++) credit_reg[i] <= '0;
    end else if (grant_fire) begin
      winner_reg <= win_idx;
      ptr_reg    <= (win_left != '0) ? win_idx :
                    ((win_idx == IW'(REQUESTS - 1)) ? '0 : win_idx + IW'(1));
      for (int i = 0; i < REQUESTS; i++) begin
        if (reload)
          credit_reg[i] <= (win_idx == IW'(i)) ? w_eff[i] - WEIGHT_WIDTH'(1) : w_eff[i];
        else if (win_idx == IW'(i))
          credit_reg[i] <= credit_reg[i] - WEIGHT_WIDTH'(1);
      end
    end
  end

`ifdef TBCM_WRR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= timeout_next;
      if (grant_fire || release_now) hold_cnt_reg <= '0;
      else if (state_reg == GRANTED) hold_cnt_reg <= hold_cnt_reg + HW'(1);
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (state_reg == GRANTED) grant[winner_reg] = 1'b1;
    else if (grant_fire)      grant[win_idx]    = 1'b1;
  end

  // Gate with rst so the grant vanishes the moment reset rises.
  assign o_grant = rst ? '0 : grant;
  assign o_busy  = (state_reg == GRANTED);
endmodule

// File: tb/tb_tbcm_weighted_round_robin_arbiter.sv
// Directed bench for tbcm_weighted_round_robin_arbiter (REQUESTS=4, WEIGHT_WIDTH=4, TIMEOUT=16).
// Covers TBCM_WRR_TIMEOUT_EN in both build variants.
module tb_tbcm_weighted_round_robin_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  request;
  logic [15:0] weight;
  logic [3:0]  free;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout;
  int          checks   = 0;
  int          failures = 0;

  tbcm_weighted_round_robin_arbiter #(
    .REQUESTS(4), .WEIGHT_WIDTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .i_request(request), .i_weight(weight),
    .i_free(free), .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; request = '0; free = '0; weight = 16'h1111;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; request = 4'b1111; free = '0; weight = 16'h1111;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: grant=%b busy=%b timeout=%b required 0000/0/0", grant, busy, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_weighted_sequence();
    int seq [10] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1};
    logic [3:0] exp;
    do_reset();
    weight = {4'd3, 4'd1, 4'd2, 4'd1};
    request = 4'b1111; free = 4'b1111;
    for (int g = 0; g < 10; g++) begin
      exp = 4'b0001 << seq[g];
      #1; checks++;
      if (grant !== exp || busy !== 1'b0) begin
        failures++;
        $display("FAIL wrr_seq_idle[%0d]: grant=%b busy=%b required %b/0", g, grant, busy, exp);
      end
      @(negedge clk); #1; checks++;
      if (grant !== exp || busy !== 1'b1) begin
        failures++;
        $display("FAIL wrr_seq_granted[%0d]: grant=%b busy=%b required %b/1", g, grant, busy, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_weight();
    do_reset();
    weight = 16'h0000; request = 4'b0100; free = 4'b0100;
    for (int g = 0; g < 3; g++) begin
      #1; checks++;
      if (grant !== 4'b0100) begin
        failures++;
        $display("FAIL zero_weight[%0d]: grant=%b required 0100", g, grant);
      end
      @(negedge clk); @(negedge clk);
    end
  endtask

  task automatic test_hold_and_ignore();
    do_reset();
    weight = 16'h1111; request = 4'b0010; free = '0;
    #1; checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL hold_first: grant=%b required 0010", grant);
    end
    @(negedge clk);
    request = '0;
    for (int c = 0; c < 5; c++) begin
      free = c[0] ? 4'b1000 : 4'b0000;
      #1; checks++;
      if (grant !== 4'b0010 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle[%0d]: grant=%b busy=%b required 0010/1", c, grant, busy);
      end
      @(negedge clk);
    end
    free = 4'b0010;
    #1; checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL hold_free_cycle: grant=%b required 0010", grant);
    end
    @(negedge clk);
    free = '0;
    #1; checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_released: grant=%b busy=%b required 0000/0", grant, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    weight = 16'h1111; request = 4'b1001; free = '0;
    #1; checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_first: grant=%b required 0001", grant);
    end
    @(negedge clk);
    free = 4'b0001;
    #1; checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_free_cycle: grant=%b busy=%b required 0001/1", grant, busy);
    end
    @(negedge clk);
    free = '0;
    #1; checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_next: grant=%b required 1000", grant);
    end
    @(negedge clk);
    free = 4'b1000;
    @(negedge clk);
    free = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    weight = 16'h1111; request = 4'b0100; free = '0;
    @(negedge clk);
    #1; checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: grant=%b busy=%b required 0100/1", grant, busy);
    end
    rst = 1'b1;
    #1; checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: grant=%b busy=%b required 0000/0", grant, busy);
    end
    @(negedge clk);
    rst = 1'b0; request = 4'b0110;
    #1; checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL midrst_after: grant=%b required 0010", grant);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    weight = 16'h1111; request = 4'b0001; free = '0;
    @(negedge clk);
`ifdef TBCM_WRR_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      #1; checks++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL to_hold[%0d]: grant=%b timeout=%b required 0001/0", c, grant, timeout);
      end
      @(negedge clk);
    end
    #1; checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse: grant=%b timeout=%b busy=%b required 0000/1/0", grant, timeout, busy);
    end
    @(negedge clk);
    #1; checks++;
    if (grant !== 4'b0001 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_resume: grant=%b timeout=%b required 0001/0", grant, timeout);
    end
`else
    for (int c = 1; c < 100; c++) @(negedge clk);
    #1; checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL nto_hold100: grant=%b busy=%b timeout=%b required 0001/1/0", grant, busy, timeout);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; request = '0; free = '0; weight = '0;
    test_reset();
    test_weighted_sequence();
    test_zero_weight();
    test_hold_and_ignore();
    test_back_to_back();
    test_reset_mid_grant();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
